// File: rtl/control_cursor.sv
// -----------------------------------------------------------------------------
// control_cursor
// Turns five raw push-buttons into a debounced cursor on a
// (GRID_MAX+1)x(GRID_MAX+1) board.
// SELECT offers the current cell to the game-logic stage over a valid/ack
// handshake. The cursor stays frozen until that stage accepts the move.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   habilitar      1 = press events accepted, 0 = press events discarded
//   btn_up/down/left/right/sel  raw active-high buttons, asynchronous to clk
//   valorX/valorY  current cursor column/row (registered)
//   jugada_x/y     cell captured at select, stable while jugada_valid=1
//   jugada_valid   move offered to game logic
//   jugada_ack     game logic accepts the offered move
// -----------------------------------------------------------------------------
module control_cursor #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned GRID_MAX        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       habilitar,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [2:0] valorX,
    output logic [2:0] valorY,
    output logic [2:0] jugada_x,
    output logic [2:0] jugada_y,
    output logic       jugada_valid,
    input  logic       jugada_ack
);

    localparam int unsigned NBTN  = 5;
    localparam int unsigned B_UP    = 0;
    localparam int unsigned B_DOWN  = 1;
    localparam int unsigned B_LEFT  = 2;
    localparam int unsigned B_RIGHT = 3;
    localparam int unsigned B_SEL   = 4;

    localparam logic [2:0]       GMAX     = 3'(GRID_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        MOVER      = 1'b0,
        ESPERA_ACK = 1'b1
    } state_t;

    // Step forward with wrap; anything at or above GRID_MAX folds back to 0.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        logic [2:0] r;
        if (v >= GMAX) begin
            r = 3'd0;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

    // Step backward with wrap; 0 (or an illegal value) goes to GRID_MAX.
    function automatic logic [2:0] wrap_dec(input logic [2:0] v);
        logic [2:0] r;
        if ((v == 3'd0) || (v > GMAX)) begin
            r = GMAX;
        end else begin
            r = v - 3'd1;
        end
        return r;
    endfunction

    logic [NBTN-1:0]  raw_s;
    logic [NBTN-1:0]  sync1_q;
    logic [NBTN-1:0]  sync2_q;
    logic [NBTN-1:0]  stable_q;
    logic [NBTN-1:0]  stable_d;
    logic [NBTN-1:0]  stable_dly_q;
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];
    logic [NBTN-1:0]  press_s;

    state_t     state_q, state_d;
    logic [2:0] x_q, x_d;
    logic [2:0] y_q, y_d;
    logic [2:0] jx_q, jx_d;
    logic [2:0] jy_q, jy_d;
    logic       valid_q, valid_d;

    assign raw_s = {btn_sel, btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new level is accepted on its DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state: counters, accepted levels and a one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q     <= '0;
            stable_dly_q <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    // Press pulse on a 0->1 of the debounced level; dropped (not queued) while disabled.
    assign press_s = stable_q & ~stable_dly_q & {NBTN{habilitar}};

    // Cursor FSM: next state, cursor movement and move capture.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        jx_d    = jx_q;
        jy_d    = jy_q;
        valid_d = valid_q;
        case (state_q)
            MOVER: begin
                if (press_s[B_SEL]) begin
                    // Capture uses the pre-move cursor; moves in the same cycle are dropped.
                    jx_d    = x_q;
                    jy_d    = y_q;
                    valid_d = 1'b1;
                    state_d = ESPERA_ACK;
                end else begin
                    // Opposite directions in the same cycle cancel each other.
                    if (press_s[B_UP] && !press_s[B_DOWN]) begin
                        y_d = wrap_dec(y_q);
                    end else if (press_s[B_DOWN] && !press_s[B_UP]) begin
                        y_d = wrap_inc(y_q);
                    end else begin
                        y_d = y_q;
                    end
                    if (press_s[B_LEFT] && !press_s[B_RIGHT]) begin
                        x_d = wrap_dec(x_q);
                    end else if (press_s[B_RIGHT] && !press_s[B_LEFT]) begin
                        x_d = wrap_inc(x_q);
                    end else begin
                        x_d = x_q;
                    end
                end
            end
            ESPERA_ACK: begin
                if (jugada_ack && valid_q) begin
                    valid_d = 1'b0;
                    state_d = MOVER;
                end else begin
                    valid_d = valid_q;
                    state_d = ESPERA_ACK;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = MOVER;
            end
        endcase
    end

    // Cursor FSM registers; reset puts the cursor in the centre and aborts any pending move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MOVER;
            x_q     <= 3'd1;
            y_q     <= 3'd1;
            jx_q    <= 3'd0;
            jy_q    <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            jx_q    <= jx_d;
            jy_q    <= jy_d;
            valid_q <= valid_d;
        end
    end

    assign valorX       = x_q;
    assign valorY       = y_q;
    assign jugada_x     = jx_q;
    assign jugada_y     = jy_q;
    assign jugada_valid = valid_q;

endmodule

// File: tb/tb_control_cursor.sv
// -----------------------------------------------------------------------------
// tb_control_cursor
// Self-checking bench for control_cursor with DEBOUNCE_CYCLES=4. A behavioural
// model tracks the raw button history and the board position arithmetically;
// every cycle the DUT outputs are compared against it, plus directed checks on
// bounce latency, wrap-around, simultaneous presses, handshake and masking.
// -----------------------------------------------------------------------------
module tb_control_cursor;

    localparam int D    = 4;
    localparam int NPOS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       habilitar = 1'b1;
    logic       jugada_ack = 1'b0;
    logic [4:0] btn_v = 5'd0;
    logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [2:0] valorX, valorY, jugada_x, jugada_y;
    logic       jugada_valid;

    assign btn_up    = btn_v[0];
    assign btn_down  = btn_v[1];
    assign btn_left  = btn_v[2];
    assign btn_right = btn_v[3];
    assign btn_sel   = btn_v[4];

    control_cursor #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(18),
        .GRID_MAX(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .habilitar(habilitar),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_sel(btn_sel),
        .valorX(valorX),
        .valorY(valorY),
        .jugada_x(jugada_x),
        .jugada_y(jugada_y),
        .jugada_valid(jugada_valid),
        .jugada_ack(jugada_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [4:0] hist[$];
    logic [4:0] m_stab;
    logic [4:0] m_pend;
    int         m_x, m_y, m_jx, m_jy;
    bit         m_valid, m_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(5'd0);
        m_stab  = 5'd0;
        m_pend  = 5'd0;
        m_x     = 1;
        m_y     = 1;
        m_jx    = 0;
        m_jy    = 0;
        m_valid = 1'b0;
        m_wait  = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs seen at that edge.
    task automatic model_edge();
        logic [4:0] ev;
        int dx, dy;
        bit all_diff;
        ev = m_pend & {5{habilitar}};
        if (!m_wait) begin
            if (ev[4]) begin
                m_jx    = m_x;
                m_jy    = m_y;
                m_valid = 1'b1;
                m_wait  = 1'b1;
            end else begin
                dy  = int'(ev[1]) - int'(ev[0]);
                dx  = int'(ev[3]) - int'(ev[2]);
                m_y = (m_y + dy + NPOS) % NPOS;
                m_x = (m_x + dx + NPOS) % NPOS;
            end
        end else if (jugada_ack) begin
            m_valid = 1'b0;
            m_wait  = 1'b0;
        end
        // A level is accepted once the D samples that reached the debouncer all disagree with it.
        hist.push_back(btn_v);
        while (hist.size() > D + 2) void'(hist.pop_front());
        for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (hist[k][b] == m_stab[b]) all_diff = 1'b0;
            end
            m_pend[b] = 1'b0;
            if (all_diff) begin
                m_stab[b] = ~m_stab[b];
                m_pend[b] = m_stab[b];
            end
        end
    endtask

    task automatic compare_all();
        check("valorX", 32'(valorX), 32'(m_x));
        check("valorY", 32'(valorY), 32'(m_y));
        check("jugada_valid", 32'(jugada_valid), 32'(m_valid));
        check("jugada_x", 32'(jugada_x), 32'(m_jx));
        check("jugada_y", 32'(jugada_y), 32'(m_jy));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valorX", 32'(valorX), 32'd1);
        check("rst_valorY", 32'(valorY), 32'd1);
        check("rst_valid", 32'(jugada_valid), 32'd0);
        check("rst_jugada_x", 32'(jugada_x), 32'd0);
        check("rst_jugada_y", 32'(jugada_y), 32'd0);
        btn_v      = 5'd0;
        jugada_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic press(input logic [4:0] m);
        btn_v = btn_v | m;
        repeat (2 * D) tick();
        btn_v = btn_v & ~m;
        repeat (2 * D) tick();
    endtask

    initial begin
        int changes, lat;
        logic [2:0] prev_y;
        int b;

        model_reset();
        do_async_reset();
        repeat (3) tick();

        // Bounce on btn_down, then a clean hold.
        changes = 0;
        lat     = 0;
        prev_y  = valorY;
        for (int i = 0; i < 20; i++) begin
            btn_v[1] = (((i / 2) % 2) == 0);
            tick();
            if (valorY != prev_y) changes++;
            prev_y = valorY;
        end
        btn_v[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (valorY != prev_y) begin
                changes++;
                if (lat == 0) lat = k;
            end
            prev_y = valorY;
        end
        check("bounce_changes", 32'(changes), 32'd1);
        check("bounce_latency", 32'(lat), 32'd7);
        check("bounce_y", 32'(valorY), 32'd2);
        btn_v[1] = 1'b0;
        repeat (2 * D) tick();

        // Wrap on X and Y.
        press(5'b01000); check("wrap_x_a", 32'(valorX), 32'd2);
        press(5'b01000); check("wrap_x_b", 32'(valorX), 32'd0);
        press(5'b01000); check("wrap_x_c", 32'(valorX), 32'd1);
        press(5'b00001);
        press(5'b00001); check("y_at_0", 32'(valorY), 32'd0);
        press(5'b00001); check("wrap_y", 32'(valorY), 32'd2);

        // Simultaneous presses.
        press(5'b00011); check("updown_y", 32'(valorY), 32'd2);
        press(5'b00001); check("y_centre", 32'(valorY), 32'd1);
        press(5'b01001);
        check("diag_x", 32'(valorX), 32'd2);
        check("diag_y", 32'(valorY), 32'd0);

        // Handshake.
        press(5'b10000);
        check("hs_valid", 32'(jugada_valid), 32'd1);
        check("hs_jx", 32'(jugada_x), 32'd2);
        check("hs_jy", 32'(jugada_y), 32'd0);
        press(5'b00010);
        press(5'b00100);
        check("hs_frozen_x", 32'(valorX), 32'd2);
        check("hs_frozen_y", 32'(valorY), 32'd0);
        check("hs_still_valid", 32'(jugada_valid), 32'd1);
        jugada_ack = 1'b1;
        tick();
        jugada_ack = 1'b0;
        check("hs_ack_clears", 32'(jugada_valid), 32'd0);
        press(5'b00010); check("hs_move_after", 32'(valorY), 32'd1);

        // Disabled: nothing gets through.
        habilitar = 1'b0;
        press(5'b11111);
        habilitar = 1'b1;
        repeat (2) tick();
        check("dis_x", 32'(valorX), 32'd2);
        check("dis_y", 32'(valorY), 32'd1);
        check("dis_valid", 32'(jugada_valid), 32'd0);

        // Randomised phase with one mid-run reset.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = int'($urandom_range(0, 4));
                btn_v[b] = ~btn_v[b];
            end
            habilitar  = ($urandom_range(0, 9) != 0);
            jugada_ack = ($urandom_range(0, 3) == 0);
            if (i == 400) do_async_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
